uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receiver: 8N1 serial to parallel, the inbound counterpart of the existing TX block. Runs on the 100 MHz system clock. Samples an asynchronous serial line and delivers each received byte with a one-cycle valid strobe. Intended to feed host commands (e.g. write data or address) into data_ctrl alongside the key inputs.

Parameters:
bps, 5208, system clocks per bit (100 MHz / 19200 baud); legal range >= 8
DATA_W, 8, data bits per frame; fixed at 8

Ports:
clk  input  1  system clock (100 MHz)
rst_n  input  1  synchronous active-low reset
rx_uart  input  1  asynchronous serial line, idle high
dout  output  8  last received byte
dout_vld  output  1  one-cycle strobe: dout valid this cycle
frame_err  output  1  one-cycle strobe: stop bit sampled low
busy  output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset is synchronous, active-low, and sampled on the clk rising edge.
- Reset values: dout=0, dout_vld=0, frame_err=0, busy=0, state=IDLE, counters=0, sync regs=all 1.
- Input synchronisation: rx_uart -> rx_s0 -> rx_s1 -> rx_s2, all flops. Logic uses only rx_s1/rx_s2.
- Start detect: rx_s2=1 and rx_s1=0 while in IDLE; call this cycle E.
- cnt_clk counts 0..bps-1 and wraps. cnt_bit counts bit index 0 (start), 1..8 (data, LSB first), 9 (stop).
- cnt_clk is 0 in cycle E+1.
- Majority sampling: hold rx_s1 at cnt_clk = bps/2-2, bps/2-1 and bps/2 (integer division). The bit value is the majority of these 3, decided at cnt_clk = bps/2.
- State machine:
  - IDLE: on start detect -> START.
  - START: at decision, bit=0 -> DATA. bit=1 -> IDLE, treated as a glitch: no strobe, no output change.
  - DATA: at each decision, shift the bit into the shift register at position (cnt_bit-1). At the cnt_clk wrap of bit 8 -> STOP.
  - STOP, bit=1: register the shift register into dout, pulse dout_vld in the next cycle (E+1+9*bps+bps/2+1), then -> IDLE.
  - STOP, bit=0: pulse frame_err in the same relative cycle, leave dout unchanged, no dout_vld, then -> BRK_WAIT.
  - BRK_WAIT: stay until rx_s1=1, then -> IDLE. This prevents a held-low line from being decoded as 0x00 frames.
- Returning to IDLE at mid-stop lets a back-to-back start bit be caught with no lost frame. Tolerance is >= +/-3% baud mismatch.
- dout_vld and frame_err are never high together, and never high on consecutive cycles.
- dout holds its value between strobes.
- Reset asserted mid-frame: everything returns to reset values on that edge, and the partial byte is discarded. After release, reception resumes only on a fresh falling edge. A line that is low at release is not a start until it has gone high then low.
- Counters are sized ceil(log2(bps)) and 4 bits. No arithmetic overflow is possible.

Test Plan:
- bps=16, send 0x55 frame -> dout_vld one cycle with dout=0x55 at E+1+9*16+8+1; frame_err stays 0; busy high from E+1 until IDLE.
- bps=16, frames 0xA3 then 0x0F back-to-back (stop bit exactly 16 clocks) -> two dout_vld pulses, dout=0xA3 then 0x0F, spaced 160 clocks apart.
- Low pulse of 4 clocks on an idle line -> no dout_vld, no frame_err, busy returns low after 9 clocks, dout unchanged.
- Frame 0x3C with stop bit low, then line held low for 40 clocks -> single frame_err pulse, no dout_vld, dout keeps its previous value; after the line goes high, a following 0x81 frame is received correctly.
- Single-clock high spike in the middle of data bit 3 of 0x00 -> majority rejects it, dout=0x00.
- rst_n low for 1 cycle during data bit 4 -> outputs at reset values next cycle, no strobe for the partial frame; next full frame 0xE7 is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with 3-sample majority voting and break handling
module uart_rx #(
    parameter int bps    = 5208,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_uart,
    output logic [DATA_W-1:0] dout,
    output logic              dout_vld,
    output logic              frame_err,
    output logic              busy
);
    localparam int CW = $clog2(bps);
    localparam logic [CW-1:0] CNT_MAX = CW'(bps - 1);
    localparam logic [CW-1:0] SMP_A   = CW'(bps / 2 - 2);
    localparam logic [CW-1:0] SMP_B   = CW'(bps / 2 - 1);
    localparam logic [CW-1:0] SMP_C   = CW'(bps / 2);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK_WAIT} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              rx_s0;
    logic              rx_s1;
    logic              rx_s2;
    logic [1:0]        settle;
    logic [CW-1:0]     cnt_clk;
    logic [3:0]        cnt_bit;
    logic              smp_a;
    logic              smp_b;
    logic [DATA_W-1:0] shift;
    logic              start_det;
    logic              end_cnt;
    logic              decide;
    logic              bit_val;
    logic [2:0]        bit_idx;

    // The sync chain resets to all-ones; edge detection waits until the chain
    // holds real line samples so a line low at reset release is not a start.
    assign start_det = (settle == 2'd3) && rx_s2 && !rx_s1;
    assign end_cnt   = (cnt_clk == CNT_MAX);
    assign decide    = (cnt_clk == SMP_C);
    assign bit_val   = (smp_a & smp_b) | (smp_a & rx_s1) | (smp_b & rx_s1);
    assign bit_idx   = 3'(cnt_bit - 4'd1);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rx_s0     <= 1'b1;
            rx_s1     <= 1'b1;
            rx_s2     <= 1'b1;
            settle    <= 2'd0;
            cnt_clk   <= '0;
            cnt_bit   <= 4'd0;
            smp_a     <= 1'b0;
            smp_b     <= 1'b0;
            shift     <= '0;
            dout      <= '0;
            dout_vld  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state <= state_nxt;
            rx_s0 <= rx_uart;
            rx_s1 <= rx_s0;
            rx_s2 <= rx_s1;
            if (settle != 2'd3) begin
                settle <= settle + 2'd1;
            end

            if (state == IDLE || state == BRK_WAIT) begin
                cnt_clk <= '0;
                cnt_bit <= 4'd0;
            end else if (end_cnt) begin
                cnt_clk <= '0;
                cnt_bit <= cnt_bit + 4'd1;
            end else begin
                cnt_clk <= cnt_clk + CW'(1);
            end

            if (cnt_clk == SMP_A) begin
                smp_a <= rx_s1;
            end
            if (cnt_clk == SMP_B) begin
                smp_b <= rx_s1;
            end

            if (state == DATA && decide && cnt_bit != 4'd0) begin
                shift[bit_idx] <= bit_val;
            end

            dout_vld  <= (state == STOP) && decide && bit_val;
            frame_err <= (state == STOP) && decide && !bit_val;
            if (state == STOP && decide && bit_val) begin
                dout <= shift;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start_det) state_nxt = START;
            START:    if (decide) state_nxt = bit_val ? IDLE : DATA;
            DATA:     if (end_cnt && cnt_bit == 4'd8) state_nxt = STOP;
            STOP:     if (decide) state_nxt = bit_val ? IDLE : BRK_WAIT;
            BRK_WAIT: if (rx_s1) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed vector bench for uart_rx at bps=16
module tb_uart_rx;
    localparam int BPS = 16;
    localparam int VLD_OFS = 2 + 1 + 9 * BPS + BPS / 2 + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_uart = 1'b1;
    logic [7:0] dout;
    logic       dout_vld;
    logic       frame_err;
    logic       busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    uart_rx #(.bps(BPS), .DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_uart   (rx_uart),
        .dout      (dout),
        .dout_vld  (dout_vld),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    int         vld_cyc_q[$];
    logic [7:0] vld_dat_q[$];
    int         ferr_n;
    int         ferr_cyc;
    int         busy_rise;
    int         busy_fall;
    int         busy_hi_n;
    logic       prev_busy = 1'b0;
    logic       prev_strobe = 1'b0;

    always @(negedge clk) begin
        if (dout_vld === 1'b1 || frame_err === 1'b1) begin
            chk("strobe_excl", int'((dout_vld & frame_err) | prev_strobe), 0);
        end
        if (dout_vld === 1'b1) begin
            vld_cyc_q.push_back(cyc);
            vld_dat_q.push_back(dout);
        end
        if (frame_err === 1'b1) begin
            ferr_n++;
            ferr_cyc = cyc;
        end
        if (busy === 1'b1) begin
            busy_hi_n++;
            if (!prev_busy && busy_rise < 0) busy_rise = cyc;
        end else if (prev_busy && busy_fall < 0) begin
            busy_fall = cyc;
        end
        prev_busy   = (busy === 1'b1);
        prev_strobe = (dout_vld === 1'b1) || (frame_err === 1'b1);
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        vld_cyc_q.delete();
        vld_dat_q.delete();
        ferr_n    = 0;
        ferr_cyc  = -1;
        busy_rise = -1;
        busy_fall = -1;
        busy_hi_n = 0;
    endtask

    // spike < 0 disables the mid-bit high spike
    task automatic send_frame(input logic [7:0] data, input logic stop, input int stop_len,
                              input int spike, output int t0);
        t0 = cyc;
        rx_uart = 1'b0;
        wait_cyc(BPS);
        for (int i = 0; i < 8; i++) begin
            rx_uart = data[i];
            if (i == spike) begin
                wait_cyc(BPS / 2);
                rx_uart = 1'b1;
                wait_cyc(1);
                rx_uart = data[i];
                wait_cyc(BPS / 2 - 1);
            end else begin
                wait_cyc(BPS);
            end
        end
        rx_uart = stop;
        wait_cyc(stop_len);
        rx_uart = 1'b1;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         n_vld;
        int         n_ferr;
        logic [7:0] exp_dout;
        int         fall_ofs;
    } vec_t;

    vec_t tbl[6];
    int   t0;
    int   t1;

    initial begin
        tbl[0] = '{8'h55, 1'b1, 1, 0, 8'h55, VLD_OFS};
        tbl[1] = '{8'hA3, 1'b1, 1, 0, 8'hA3, VLD_OFS};
        tbl[2] = '{8'h00, 1'b1, 1, 0, 8'h00, VLD_OFS};
        tbl[3] = '{8'hFF, 1'b1, 1, 0, 8'hFF, VLD_OFS};
        tbl[4] = '{8'h3C, 1'b0, 0, 1, 8'hFF, 10 * BPS + 3};
        tbl[5] = '{8'h81, 1'b1, 1, 0, 8'h81, VLD_OFS};

        wait_cyc(4);
        chk("rst_dout", int'(dout), 0);
        chk("rst_vld", int'(dout_vld), 0);
        chk("rst_ferr", int'(frame_err), 0);
        chk("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        wait_cyc(10);

        for (int v = 0; v < 6; v++) begin
            clear_mon();
            send_frame(tbl[v].data, tbl[v].stop, BPS, -1, t0);
            wait_cyc(30);
            chk($sformatf("v%0d_nvld", v), vld_cyc_q.size(), tbl[v].n_vld);
            chk($sformatf("v%0d_nferr", v), ferr_n, tbl[v].n_ferr);
            chk($sformatf("v%0d_dout", v), int'(dout), int'(tbl[v].exp_dout));
            chk($sformatf("v%0d_rise", v), busy_rise, t0 + 3);
            chk($sformatf("v%0d_fall", v), busy_fall, t0 + tbl[v].fall_ofs);
            if (tbl[v].n_vld == 1 && vld_cyc_q.size() > 0) begin
                chk($sformatf("v%0d_vld_cyc", v), vld_cyc_q[0], t0 + VLD_OFS);
                chk($sformatf("v%0d_vld_dat", v), int'(vld_dat_q[0]), int'(tbl[v].data));
            end
            if (tbl[v].n_ferr == 1) begin
                chk($sformatf("v%0d_ferr_cyc", v), ferr_cyc, t0 + VLD_OFS);
            end
        end

        // back-to-back frames, stop bit exactly one bit time
        clear_mon();
        send_frame(8'hA3, 1'b1, BPS, -1, t0);
        send_frame(8'h0F, 1'b1, BPS, -1, t1);
        wait_cyc(30);
        chk("b2b_nvld", vld_cyc_q.size(), 2);
        chk("b2b_nferr", ferr_n, 0);
        if (vld_cyc_q.size() == 2) begin
            chk("b2b_cyc0", vld_cyc_q[0], t0 + VLD_OFS);
            chk("b2b_space", vld_cyc_q[1] - vld_cyc_q[0], 10 * BPS);
            chk("b2b_dat0", int'(vld_dat_q[0]), 8'hA3);
            chk("b2b_dat1", int'(vld_dat_q[1]), 8'h0F);
        end

        // 4-clock low glitch on idle line
        clear_mon();
        t0 = cyc;
        rx_uart = 1'b0;
        wait_cyc(4);
        rx_uart = 1'b1;
        wait_cyc(30);
        chk("glitch_nvld", vld_cyc_q.size(), 0);
        chk("glitch_nferr", ferr_n, 0);
        chk("glitch_busy_n", busy_hi_n, 9);
        chk("glitch_fall", busy_fall, t0 + 12);
        chk("glitch_dout", int'(dout), 8'h0F);

        // framing error with line held low, then recovery
        clear_mon();
        send_frame(8'h3C, 1'b0, 40, -1, t0);
        wait_cyc(20);
        chk("brk_nferr", ferr_n, 1);
        chk("brk_ferr_cyc", ferr_cyc, t0 + VLD_OFS);
        chk("brk_nvld", vld_cyc_q.size(), 0);
        chk("brk_dout", int'(dout), 8'h0F);
        clear_mon();
        send_frame(8'h81, 1'b1, BPS, -1, t0);
        wait_cyc(30);
        chk("brk_rec_nvld", vld_cyc_q.size(), 1);
        chk("brk_rec_dout", int'(dout), 8'h81);
        if (vld_cyc_q.size() > 0) chk("brk_rec_cyc", vld_cyc_q[0], t0 + VLD_OFS);

        // reset pulse in data bit 4 of 0x0F; line is low at release
        clear_mon();
        rx_uart = 1'b0;
        wait_cyc(BPS);
        for (int i = 0; i < 4; i++) begin
            rx_uart = 1'b1;
            wait_cyc(BPS);
        end
        rx_uart = 1'b0;
        wait_cyc(BPS / 2);
        rst_n = 1'b0;
        wait_cyc(1);
        rst_n = 1'b1;
        chk("mrst_dout", int'(dout), 0);
        chk("mrst_vld", int'(dout_vld), 0);
        chk("mrst_ferr", int'(frame_err), 0);
        chk("mrst_busy", int'(busy), 0);
        wait_cyc(BPS / 2 - 1 + 3 * BPS);
        rx_uart = 1'b1;
        wait_cyc(BPS + 20);
        chk("mrst_nvld", vld_cyc_q.size(), 0);
        chk("mrst_nferr", ferr_n, 0);
        clear_mon();
        send_frame(8'hE7, 1'b1, BPS, -1, t0);
        wait_cyc(30);
        chk("mrst_e7_nvld", vld_cyc_q.size(), 1);
        chk("mrst_e7_dout", int'(dout), 8'hE7);
        if (vld_cyc_q.size() > 0) chk("mrst_e7_cyc", vld_cyc_q[0], t0 + VLD_OFS);

        // single-clock spike inside data bit 3 of 0x00
        clear_mon();
        send_frame(8'h00, 1'b1, BPS, 3, t0);
        wait_cyc(30);
        chk("spike_nvld", vld_cyc_q.size(), 1);
        chk("spike_dout", int'(dout), 8'h00);
        chk("spike_nferr", ferr_n, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
